tage_counter_table: RTL and testbench

Tagged-component prediction counter store for the TAGE predictor. It sits directly downstream of the counter-update stage and consumes that stage's `inc_counter`/`dec_counter` pair to saturate per-entry CTR_W-bit counters. It also serves the lookup path with a one-cycle registered read. After every reset it clears itself with a hardware sweep.

---
 rtl/tage_pkg.sv | 24 ++
 rtl/tage_ctr_next.sv | 29 ++
 rtl/tage_counter_table.sv | 116 +++++++++++
 tb/tb_tage_counter_table.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tage_pkg.sv
// Shared definitions for the TAGE counter tables: FSM states, default counter
// width and the weak/saturation constants derived from a counter width.
package tage_pkg;

   localparam int CTR_W_DEFAULT = 3;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } state_t;

   function automatic int ctr_wnt(input int w);
      return (32'sd1 << (w - 32'sd1)) - 32'sd1;
   endfunction

   function automatic int ctr_wt(input int w);
      return 32'sd1 << (w - 32'sd1);
   endfunction

   function automatic int ctr_max(input int w);
      return (32'sd1 << w) - 32'sd1;
   endfunction

endpackage

// File: rtl/tage_ctr_next.sv
// Saturating next-value logic for a prediction counter; an inc/dec pair that
// is both set or both clear leaves the value unchanged.
module tage_ctr_next
   import tage_pkg::*;
#(
   parameter int CTR_W = CTR_W_DEFAULT
) (
   input  logic [CTR_W-1:0] value,
   input  logic             inc_counter,
   input  logic             dec_counter,
   output logic [CTR_W-1:0] next_value
);

   localparam logic [CTR_W-1:0] MAX = CTR_W'(ctr_max(CTR_W));

   always_comb begin
      next_value = value;
      if (inc_counter && !dec_counter) begin
         if (value != MAX) next_value = value + CTR_W'(1);
         else              next_value = value;
      end else if (dec_counter && !inc_counter) begin
         if (value != {CTR_W{1'b0}}) next_value = value - CTR_W'(1);
         else                        next_value = value;
      end else begin
         next_value = value;
      end
   end

endmodule

// File: rtl/tage_counter_table.sv
// Tagged-component counter store: clear sweep after reset, saturating updates,
// allocation re-initialisation and a one-cycle registered read-before-write port.
module tage_counter_table
   import tage_pkg::*;
#(
   parameter int IDX_W = 10,
   parameter int CTR_W = CTR_W_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   output logic             init_busy,
   input  logic             rd_en,
   input  logic [IDX_W-1:0] rd_index,
   output logic             rd_valid,
   output logic [CTR_W-1:0] rd_ctr,
   output logic             rd_taken,
   output logic             rd_weak,
   input  logic             upd_en,
   input  logic [IDX_W-1:0] upd_index,
   input  logic             inc_counter,
   input  logic             dec_counter,
   input  logic             alloc_en,
   input  logic [IDX_W-1:0] alloc_index,
   input  logic             alloc_taken
);

   localparam int               DEPTH    = 2 ** IDX_W;
   localparam logic [CTR_W-1:0] WNT      = CTR_W'(ctr_wnt(CTR_W));
   localparam logic [CTR_W-1:0] WT       = CTR_W'(ctr_wt(CTR_W));
   localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

   state_t           state;
   state_t           state_next;
   logic [IDX_W-1:0] ptr;
   logic [CTR_W-1:0] mem [DEPTH];
   logic [CTR_W-1:0] upd_cur;
   logic [CTR_W-1:0] upd_next;
   logic [CTR_W-1:0] rd_word;
   logic [CTR_W-1:0] alloc_val;
   logic             ready;
   logic             alloc_write;
   logic             upd_write;

   tage_ctr_next #(.CTR_W(CTR_W)) u_ctr_next (
      .value       (upd_cur),
      .inc_counter (inc_counter),
      .dec_counter (dec_counter),
      .next_value  (upd_next)
   );

   // A same-index allocation overrides the update in the same cycle.
   always_comb begin
      ready       = (state == READY) && !reset;
      rd_word     = mem[rd_index];
      upd_cur     = mem[upd_index];
      alloc_val   = alloc_taken ? WT : WNT;
      alloc_write = ready && alloc_en;
      upd_write   = ready && upd_en && !(alloc_write && (alloc_index == upd_index));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= INIT;
         ptr   <= {IDX_W{1'b0}};
      end else begin
         state <= state_next;
         if (state == INIT) ptr <= ptr + IDX_W'(1);
         else               ptr <= ptr;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         INIT:    state_next = (ptr == LAST_IDX) ? READY : INIT;
         READY:   state_next = READY;
         default: state_next = INIT;
      endcase
   end

   always_comb begin
      init_busy = 1'b1;
      case (state)
         INIT:    init_busy = 1'b1;
         READY:   init_busy = 1'b0;
         default: init_busy = 1'b1;
      endcase
   end

   // Array contents survive reset; only the sweep clears them.
   always_ff @(posedge clk) begin
      if (!reset && (state == INIT)) begin
         mem[ptr] <= WNT;
      end else begin
         if (alloc_write) mem[alloc_index] <= alloc_val;
         if (upd_write)   mem[upd_index]   <= upd_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_valid <= 1'b0;
         rd_ctr   <= {CTR_W{1'b0}};
         rd_taken <= 1'b0;
         rd_weak  <= 1'b0;
      end else if (ready && rd_en) begin
         rd_valid <= 1'b1;
         rd_ctr   <= rd_word;
         rd_taken <= rd_word[CTR_W-1];
         rd_weak  <= (rd_word == WNT) || (rd_word == WT);
      end else begin
         rd_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tage_counter_table.sv
// Scoreboard bench for tage_counter_table with IDX_W=4, CTR_W=3: expected read
// values are queued from a bench-side model when a read is issued.
module tb_tage_counter_table;

   logic       clk = 1'b0;
   logic       reset;
   logic       init_busy;
   logic       rd_en;
   logic [3:0] rd_index;
   logic       rd_valid;
   logic [2:0] rd_ctr;
   logic       rd_taken;
   logic       rd_weak;
   logic       upd_en;
   logic [3:0] upd_index;
   logic       inc_counter;
   logic       dec_counter;
   logic       alloc_en;
   logic [3:0] alloc_index;
   logic       alloc_taken;

   int checks = 0;
   int errors = 0;
   int model [16];
   bit model_ready = 1'b0;
   int exp_q [$];

   tage_counter_table #(.IDX_W(4), .CTR_W(3)) dut (
      .clk         (clk),
      .reset       (reset),
      .init_busy   (init_busy),
      .rd_en       (rd_en),
      .rd_index    (rd_index),
      .rd_valid    (rd_valid),
      .rd_ctr      (rd_ctr),
      .rd_taken    (rd_taken),
      .rd_weak     (rd_weak),
      .upd_en      (upd_en),
      .upd_index   (upd_index),
      .inc_counter (inc_counter),
      .dec_counter (dec_counter),
      .alloc_en    (alloc_en),
      .alloc_index (alloc_index),
      .alloc_taken (alloc_taken)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic idle();
      rd_en = 1'b0; rd_index = 4'd0;
      upd_en = 1'b0; upd_index = 4'd0; inc_counter = 1'b0; dec_counter = 1'b0;
      alloc_en = 1'b0; alloc_index = 4'd0; alloc_taken = 1'b0;
   endtask

   // One clock: queue expectations from the model, advance, then check.
   task automatic step();
      bit do_rd, w_alloc, w_upd;
      int nv, e, ai, ui, av;
      do_rd   = rd_en && model_ready;
      w_alloc = alloc_en && model_ready;
      w_upd   = upd_en && model_ready && !(w_alloc && (alloc_index == upd_index));
      ai = int'(alloc_index);
      ui = int'(upd_index);
      av = alloc_taken ? 4 : 3;
      if (do_rd) exp_q.push_back(model[rd_index]);
      nv = model[ui];
      if (inc_counter && !dec_counter) nv = (nv < 7) ? nv + 1 : 7;
      else if (dec_counter && !inc_counter) nv = (nv > 0) ? nv - 1 : 0;
      @(posedge clk); #1;
      if (w_alloc) model[ai] = av;
      if (w_upd) model[ui] = nv;
      checks++;
      if (do_rd) begin
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: no expected entry");
         end else begin
            e = exp_q.pop_front();
            if (rd_valid !== 1'b1 || rd_ctr !== 3'(e) || rd_taken !== (e >= 4) ||
                rd_weak !== (e == 3 || e == 4)) begin
               errors++;
               $display("FAIL read: valid=%b ctr=%0d taken=%b weak=%b required valid=1 ctr=%0d taken=%b weak=%b",
                        rd_valid, rd_ctr, rd_taken, rd_weak, e, (e >= 4), (e == 3 || e == 4));
            end
         end
      end else if (rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL rd_valid_idle: got %b required 0", rd_valid);
      end
   endtask

   task automatic check_busy(input logic exp, input string name);
      checks++;
      if (init_busy !== exp) begin
         errors++;
         $display("FAIL %s: init_busy=%b required %b", name, init_busy, exp);
      end
   endtask

   // Release reset and confirm the sweep lasts exactly 16 cycles.
   task automatic run_sweep(input bit pulse_ops);
      reset = 1'b0;
      for (int k = 0; k < 16; k++) begin
         check_busy(1'b1, "sweep_busy");
         if (pulse_ops && k[0]) begin
            rd_en = 1'b1; rd_index = 4'd9;
            upd_en = 1'b1; upd_index = 4'd9; inc_counter = 1'b1;
            alloc_en = 1'b1; alloc_index = 4'd9; alloc_taken = 1'b1;
         end else begin
            idle();
         end
         step();
      end
      idle();
      check_busy(1'b0, "sweep_done");
      for (int i = 0; i < 16; i++) model[i] = 3;
      model_ready = 1'b1;
   endtask

   task automatic read(input int idx);
      idle(); rd_en = 1'b1; rd_index = 4'(idx); step(); idle();
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      model_ready = 1'b0;
      step(); step();
      checks++;
      if (rd_ctr !== 3'd0 || rd_taken !== 1'b0 || rd_weak !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: ctr=%0d taken=%b weak=%b required 0 0 0", rd_ctr, rd_taken, rd_weak);
      end
      check_busy(1'b1, "reset_busy");
      run_sweep(1'b0);
      for (int i = 0; i < 16; i++) read(i);
   endtask

   task automatic test_saturate();
      int seq [5] = '{4, 5, 6, 7, 7};
      for (int k = 0; k < 5; k++) begin
         idle(); upd_en = 1'b1; upd_index = 4'd5; inc_counter = 1'b1; step();
         read(5);
         checks++;
         if (rd_ctr !== 3'(seq[k])) begin
            errors++;
            $display("FAIL inc_sequence: step %0d ctr=%0d required %0d", k, rd_ctr, seq[k]);
         end
      end
      for (int k = 0; k < 9; k++) begin
         idle(); upd_en = 1'b1; upd_index = 4'd5; dec_counter = 1'b1; step();
      end
      read(5);
      checks++;
      if (rd_ctr !== 3'd0) begin
         errors++;
         $display("FAIL dec_floor: ctr=%0d required 0", rd_ctr);
      end
   endtask

   task automatic test_conflicts();
      idle(); upd_en = 1'b1; upd_index = 4'd2; inc_counter = 1'b1; dec_counter = 1'b1; step();
      read(2);
      idle(); upd_en = 1'b1; upd_index = 4'd2; inc_counter = 1'b1;
      alloc_en = 1'b1; alloc_index = 4'd2; alloc_taken = 1'b0; step();
      read(2);
      idle(); upd_en = 1'b1; upd_index = 4'd2; inc_counter = 1'b1;
      alloc_en = 1'b1; alloc_index = 4'd2; alloc_taken = 1'b1; step();
      read(2);
      checks++;
      if (rd_ctr !== 3'd4) begin
         errors++;
         $display("FAIL alloc_wins: ctr=%0d required 4", rd_ctr);
      end
      idle(); upd_en = 1'b1; upd_index = 4'd12; dec_counter = 1'b1;
      alloc_en = 1'b1; alloc_index = 4'd11; alloc_taken = 1'b1; step();
      read(11); read(12);
   endtask

   task automatic test_read_before_write();
      idle(); rd_en = 1'b1; rd_index = 4'd7;
      upd_en = 1'b1; upd_index = 4'd7; inc_counter = 1'b1; step();
      checks++;
      if (rd_ctr !== 3'd3) begin
         errors++;
         $display("FAIL rbw_old: ctr=%0d required 3", rd_ctr);
      end
      read(7);
      checks++;
      if (rd_ctr !== 3'd4) begin
         errors++;
         $display("FAIL rbw_new: ctr=%0d required 4", rd_ctr);
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 300; k++) begin
         rd_en = 1'($urandom_range(0, 1)); rd_index = 4'($urandom_range(0, 15));
         upd_en = 1'($urandom_range(0, 1)); upd_index = 4'($urandom_range(0, 15));
         inc_counter = 1'($urandom_range(0, 1)); dec_counter = 1'($urandom_range(0, 1));
         alloc_en = ($urandom_range(0, 3) == 0); alloc_index = 4'($urandom_range(0, 15));
         alloc_taken = 1'($urandom_range(0, 1));
         step();
      end
      idle();
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 4; k++) begin
         idle(); upd_en = 1'b1; upd_index = 4'd9; inc_counter = 1'b1; step();
      end
      for (int k = 0; k < 4; k++) begin
         idle(); upd_en = 1'b1; upd_index = 4'd9; dec_counter = 1'b0; inc_counter = 1'b1; step();
      end
      idle(); alloc_en = 1'b1; alloc_index = 4'd9; alloc_taken = 1'b1; step();
      for (int k = 0; k < 3; k++) begin
         idle(); upd_en = 1'b1; upd_index = 4'd9; inc_counter = 1'b1; step();
      end
      read(9);
      checks++;
      if (rd_ctr !== 3'd7) begin
         errors++;
         $display("FAIL pre_reset_entry9: ctr=%0d required 7", rd_ctr);
      end
      idle();
      reset = 1'b1;
      model_ready = 1'b0;
      step();
      check_busy(1'b1, "mid_reset_busy");
      run_sweep(1'b1);
      read(9);
      checks++;
      if (rd_ctr !== 3'd3) begin
         errors++;
         $display("FAIL post_sweep_entry9: ctr=%0d required 3", rd_ctr);
      end
      for (int i = 0; i < 16; i++) read(i);
   endtask

   initial begin
      idle();
      reset = 1'b1;
      test_reset();
      test_saturate();
      test_conflicts();
      test_read_before_write();
      test_back_to_back();
      test_reset_mid();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover: %0d entries required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
